reg_init_bank: RTL and testbench
================================

REG_INIT_BANK -- requirements
Module: reg_init_bank

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each channel register (>=1).
REQ-002 Parameter CHANNELS, default 4, number of independent channel registers (>=2).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port init_val  input  CHANNELS*WIDTH  per-channel runtime init value; channel i at bits [i*WIDTH +: WIDTH].
REQ-006 Port wr_en  input  CHANNELS  per-channel write enable.
REQ-007 Port wr_data  input  CHANNELS*WIDTH  per-channel write data, same packing as init_val.
REQ-008 Port restore_req  input  1  request to restore masked channels to init_val.
REQ-009 Port restore_mask  input  CHANNELS  channels selected by restore_req.
REQ-010 Port q  output  CHANNELS*WIDTH  channel register contents, same packing.
REQ-011 Port dirty  output  CHANNELS  channel written since its last init or restore.
REQ-012 Port busy  output  1  restore sequence in progress.
REQ-013 Port restore_done  output  1  one-cycle pulse: restore sequence completed.

Function
REQ-014 Design SHALL be two-state FSM: IDLE, SCAN; plus registered pending mask (CHANNELS bits).
REQ-015 Outside reset and restore, wr_en[i]=1 at an edge SHALL load q[i]<=wr_data[i] and set dirty[i]; wr_en[i]=0 holds q[i] and dirty[i].
REQ-016 In IDLE, restore_req=1 with restore_mask!=0 SHALL latch pending<=restore_mask and enter SCAN; busy=1 from that edge.
REQ-017 In IDLE, restore_req=1 with restore_mask==0 SHALL stay IDLE, busy=0, and pulse restore_done for the following cycle.
REQ-018 In SCAN, each edge SHALL restore exactly one channel: lowest-index set pending bit j; q[j]<=init_val[j] as sampled at that edge; dirty[j]<=0; pending[j]<=0.
REQ-019 Restore of k channels SHALL take exactly k edges after the request edge; busy high k cycles.
REQ-020 At the edge restoring the last pending channel, FSM SHALL return to IDLE, busy<=0, restore_done<=1 for exactly one cycle.
REQ-021 restore_req while busy=1 SHALL be ignored (no queuing, no effect on pending).
REQ-022 wr_en[j] on the edge channel j is being restored: restore wins, q[j]=init_val[j], dirty[j]=0.
REQ-023 wr_en to a channel still pending (not yet restored) SHALL write normally; the later restore overwrites it.
REQ-024 wr_en to non-pending channels during SCAN SHALL behave as REQ-015.
REQ-025 init_val SHALL NOT be stored; only its value at the reset or restore edge matters.
REQ-026 restore_req and wr_en on the same IDLE edge: writes apply at that edge; restores begin next edge per REQ-018.
REQ-027 restore_done SHALL NOT be asserted in the same cycle as busy.

Reset
REQ-028 rst=1 at an edge SHALL load q[i]<=init_val[i] for all i (non-literal reset value), dirty<=0, pending<=0, busy<=0, restore_done<=0, FSM<=IDLE.
REQ-029 rst SHALL override wr_en and restore_req; reset during SCAN aborts the sequence with no restore_done pulse.
REQ-030 rst held over multiple edges SHALL track init_val changes each edge.

Verification (CHANNELS=4, WIDTH=8)
REQ-031 rst=1 with init_val={8'h44,8'h33,8'h22,8'h11}, then rst=0 -> q={44,33,22,11}, dirty=0, busy=0.
REQ-032 After reset, wr_en=4'b0101, wr_data all 8'hAA -> q={44,AA,22,AA}, dirty=4'b0101; next edge no wr_en -> unchanged.
REQ-033 restore_req, restore_mask=4'b1010, init_val unchanged -> ch1 restored edge 1, ch3 edge 2; busy high 2 cycles; restore_done one cycle after; dirty bits 1,3 cleared.
REQ-034 restore_mask=4'b1111, wr_en[2]=1 data 8'h5C on edge restoring ch2, wr_en[3]=1 data 8'h77 on edge restoring ch0 -> final q2=init, q3=init (restore overwrites), busy 4 cycles; second restore_req during busy ignored.
REQ-035 restore_mask=0 -> busy stays 0, restore_done pulses next cycle, q unchanged.
REQ-036 rst asserted mid-SCAN after 1 of 3 channels restored, init_val changed to 8'hF0 each -> all q=F0, busy=0, no restore_done.

Source files
------------

// File: rtl/reg_init_bank.sv
// Bank of CHANNELS registers with per-channel write and a runtime init value.
// A restore request walks the masked channels one per cycle, lowest index first.
module reg_init_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] init_val,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    input  logic                      restore_req,
    input  logic [CHANNELS-1:0]       restore_mask,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      busy,
    output logic                      restore_done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CHANNELS-1:0]         pending_q, pending_d;
    logic [CHANNELS*WIDTH-1:0]   q_q, q_d;
    logic [CHANNELS-1:0]         dirty_q, dirty_d;
    logic                        done_q, done_d;
    logic [CHANNELS-1:0]         sel_s;

    // One-hot of the lowest set bit; all zeros when nothing is set.
    function automatic logic [CHANNELS-1:0] lowest_one(input logic [CHANNELS-1:0] v);
        logic [CHANNELS-1:0] r;
        logic                found;
        r     = {CHANNELS{1'b0}};
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end else begin
                r[i]  = 1'b0;
            end
        end
        return r;
    endfunction

    // Next-state logic for the FSM, pending mask and channel registers.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        q_d       = q_q;
        dirty_d   = dirty_q;
        sel_s     = {CHANNELS{1'b0}};

        case (state_q)
            IDLE: begin
                if (restore_req) begin
                    if (restore_mask != {CHANNELS{1'b0}}) begin
                        pending_d = restore_mask;
                        state_d   = SCAN;
                    end else begin
                        done_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // restore_req is deliberately not looked at here: no queuing.
                sel_s     = lowest_one(pending_q);
                pending_d = pending_q & ~sel_s;
                if (pending_d == {CHANNELS{1'b0}}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = {CHANNELS{1'b0}};
            end
        endcase

        // A restore on a channel beats a write to it on the same edge.
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_s[i]) begin
                q_d[i*WIDTH +: WIDTH] = init_val[i*WIDTH +: WIDTH];
                dirty_d[i]            = 1'b0;
            end else if (wr_en[i]) begin
                q_d[i*WIDTH +: WIDTH] = wr_data[i*WIDTH +: WIDTH];
                dirty_d[i]            = 1'b1;
            end else begin
                q_d[i*WIDTH +: WIDTH] = q_q[i*WIDTH +: WIDTH];
                dirty_d[i]            = dirty_q[i];
            end
        end
    end

    // State registers; reset loads the live init value rather than a constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= {CHANNELS{1'b0}};
            q_q       <= init_val;
            dirty_q   <= {CHANNELS{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            q_q       <= q_d;
            dirty_q   <= dirty_d;
            done_q    <= done_d;
        end
    end

    assign q            = q_q;
    assign dirty        = dirty_q;
    assign busy         = (state_q == SCAN);
    assign restore_done = done_q;

endmodule

// File: tb/tb_reg_init_bank.sv
// Directed bench for reg_init_bank: stimulus pushes hand-computed post-edge
// expectations into a scoreboard queue, a negedge monitor pops and compares.
module tb_reg_init_bank;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk;
    logic           rst;
    logic [C*W-1:0] init_val;
    logic [C-1:0]   wr_en;
    logic [C*W-1:0] wr_data;
    logic           restore_req;
    logic [C-1:0]   restore_mask;
    logic [C*W-1:0] q;
    logic [C-1:0]   dirty;
    logic           busy;
    logic           restore_done;

    typedef struct packed {
        logic [C*W-1:0] q;
        logic [C-1:0]   dirty;
        logic           busy;
        logic           done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;

    reg_init_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .init_val     (init_val),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .restore_req  (restore_req),
        .restore_mask (restore_mask),
        .q            (q),
        .dirty        (dirty),
        .busy         (busy),
        .restore_done (restore_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: drive inputs, then record what must hold after the edge.
    task automatic cyc(input logic r, input logic [31:0] iv, input logic [3:0] we,
                       input logic [31:0] wd, input logic rr, input logic [3:0] rm,
                       input logic [31:0] eq, input logic [3:0] ed,
                       input logic eb, input logic edn);
        exp_t e;
        rst          = r;
        init_val     = iv;
        wr_en        = we;
        wr_data      = wd;
        restore_req  = rr;
        restore_mask = rm;
        @(posedge clk);
        e.q     = eq;
        e.dirty = ed;
        e.busy  = eb;
        e.done  = edn;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: every cycle is an output sample; compare it against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_pop++;
                n_cmp++;
                if (q !== e.q) begin
                    n_fail++;
                    $display("FAIL q step %0d: got %h expected %h", n_pop, q, e.q);
                end
                n_cmp++;
                if (dirty !== e.dirty) begin
                    n_fail++;
                    $display("FAIL dirty step %0d: got %b expected %b", n_pop, dirty, e.dirty);
                end
                n_cmp++;
                if (busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL busy step %0d: got %b expected %b", n_pop, busy, e.busy);
                end
                n_cmp++;
                if (restore_done !== e.done) begin
                    n_fail++;
                    $display("FAIL restore_done step %0d: got %b expected %b", n_pop, restore_done, e.done);
                end
            end
        end
    end

    localparam logic [31:0] INIT = 32'h4433_2211;

    initial begin
        //   rst  init_val      wr_en    wr_data       req   mask     exp q          dirty    busy  done
        // Reset, tracking an init_val change while rst is held.
        cyc(1'b1, 32'h4433_2299, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'h4433_2299, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, INIT,          4'b1111, 32'hFFFF_FFFF, 1'b1, 4'b1111, INIT,          4'b0000, 1'b0, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, INIT,          4'b0000, 1'b0, 1'b0);
        // Plain writes, then hold.
        cyc(1'b0, INIT,          4'b0101, 32'hAAAA_AAAA, 1'b0, 4'b0000, 32'h44AA_22AA, 4'b0101, 1'b0, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h1234_5678, 1'b0, 4'b0000, 32'h44AA_22AA, 4'b0101, 1'b0, 1'b0);
        // Restore mask 1010: ch1 then ch3.
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b1, 4'b1010, 32'h44AA_22AA, 4'b0101, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h44AA_22AA, 4'b0101, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h44AA_22AA, 4'b0101, 1'b0, 1'b1);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h44AA_22AA, 4'b0101, 1'b0, 1'b0);
        // Restore mask 0101 with a write on the request edge; init ch2 changes at its restore edge.
        cyc(1'b0, INIT,          4'b0010, 32'h0000_BB00, 1'b1, 4'b0101, 32'h44AA_BBAA, 4'b0111, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h44AA_BB11, 4'b0110, 1'b1, 1'b0);
        cyc(1'b0, 32'h4466_2211, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'h4466_BB11, 4'b0010, 1'b0, 1'b1);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h4466_BB11, 4'b0010, 1'b0, 1'b0);
        // Restore all: write to pending ch3, ignored requests, restore wins on ch2.
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b1, 4'b1111, 32'h4466_BB11, 4'b0010, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b1000, 32'h7700_0000, 1'b0, 4'b0000, 32'h7766_BB11, 4'b1010, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b1, 4'b0001, 32'h7766_2211, 4'b1000, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0100, 32'h005C_0000, 1'b0, 4'b0000, 32'h7733_2211, 4'b1000, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b1, 4'b0100, INIT,          4'b0000, 1'b0, 1'b1);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, INIT,          4'b0000, 1'b0, 1'b0);
        // Empty mask: immediate done pulse, never busy.
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b1, 4'b0000, INIT,          4'b0000, 1'b0, 1'b1);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, INIT,          4'b0000, 1'b0, 1'b0);
        // Reset aborts a scan after one of three channels.
        cyc(1'b0, INIT,          4'b0010, 32'h0000_CC00, 1'b1, 4'b0111, 32'h4433_CC11, 4'b0010, 1'b1, 1'b0);
        cyc(1'b0, INIT,          4'b0000, 32'h0,        1'b0, 4'b0000, 32'h4433_CC11, 4'b0010, 1'b1, 1'b0);
        cyc(1'b1, 32'hF0F0_F0F0, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'hF0F0_F0F0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 32'h0102_0304, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'hF0F0_F0F0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 32'h0102_0304, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'hF0F0_F0F0, 4'b0000, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
